// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
//   Bundles the two buses of the instruction fetch sequencer:
//     - the program-memory read port (valid handshake)
//     - the decoder issue port (registered word plus one-cycle enable)
//
//   Signals:
//     pmem_addr  [PC_WIDTH]     fetch address, driven by the sequencer
//     pmem_rd                   read request, high for every fetch cycle
//     pmem_data  [INSTR_WIDTH]  read data from program memory
//     pmem_valid                pmem_data is valid for the current request
//     instr      [INSTR_WIDTH]  instruction presented to the decoder
//     id_ce                     decoder enable, one pulse per instruction
//
//   Modports:
//     master  the sequencer (instr_fetch)
//     slave   program memory plus decoder side
// ---------------------------------------------------------------------------
interface instr_fetch_if #(
  parameter int PC_WIDTH    = 4,
  parameter int INSTR_WIDTH = 6
) ();

  logic [PC_WIDTH-1:0]    pmem_addr;
  logic                   pmem_rd;
  logic [INSTR_WIDTH-1:0] pmem_data;
  logic                   pmem_valid;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   id_ce;

  modport master (
    output pmem_addr,
    output pmem_rd,
    input  pmem_data,
    input  pmem_valid,
    output instr,
    output id_ce
  );

  modport slave (
    input  pmem_addr,
    input  pmem_rd,
    output pmem_data,
    output pmem_valid,
    input  instr,
    input  id_ce
  );

endinterface : instr_fetch_if

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch/issue sequencer for the 4-bit core. Owns the program
//   counter, fetches one word at a time from program memory over a valid
//   handshake and issues it to the decoder with a one-cycle id_ce pulse.
//   Supports run/halt control and a single-target jump sampled at issue.
//
//   Decoder-side field layout of instr:
//     [1:0] register address, [4:2] ALU opcode, [5] accumulator enable.
//
//   Ports:
//     clk       system clock, rising edge
//     rst_n     asynchronous active-low reset
//     start     level; begin or resume fetching from the current pc
//     halt      level; stop after the in-flight instruction is issued
//     jmp_en    jump request, only looked at while issuing
//     jmp_addr  jump target
//     bus       instr_fetch_if.master (program memory + decoder ports)
//     pc        current program counter
//     halted    high while the sequencer is halted
//
//   Every output is a register; the combinational block computes the value
//   each output takes after the next edge, so nothing downstream ever sees
//   a decode glitch. Zero-wait timing: start sampled at edge k -> pmem_rd in
//   cycle k+1 -> id_ce in cycle k+2; steady state is one word per 2 cycles.
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int PC_WIDTH    = 4,
  parameter int INSTR_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                halt,
  input  logic                jmp_en,
  input  logic [PC_WIDTH-1:0] jmp_addr,
  instr_fetch_if.master       bus,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALTED
  } state_t;

  state_t                 state;
  state_t                 state_next;

  logic [PC_WIDTH-1:0]    pc_next;
  logic [PC_WIDTH-1:0]    pc_seq;
  logic [PC_WIDTH-1:0]    pmem_addr_next;
  logic                   pmem_rd_next;
  logic [INSTR_WIDTH-1:0] instr_next;
  logic                   id_ce_next;
  logic                   halted_next;
  logic                   accept;

  // Sequential successor; the carry out is dropped so the pc wraps naturally.
  assign pc_seq = pc + 1'b1;

  // The read request is only ever high in FETCH, so qualifying with it makes
  // stray pmem_valid pulses in any other state harmless.
  assign accept = bus.pmem_rd & bus.pmem_valid;

  // -------------------------------------------------------------------------
  // Next-state and next-output logic.
  // NOTE: every signal assigned in this block gets a default before the case
  // statement, so no path can leave one unassigned and infer a latch.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    pmem_addr_next = bus.pmem_addr;
    pmem_rd_next   = 1'b0;
    instr_next     = bus.instr;
    id_ce_next     = 1'b0;
    halted_next    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (halt) begin
          // halt wins over start when both are raised together
          state_next  = S_HALTED;
          halted_next = 1'b1;
        end else if (start) begin
          state_next     = S_FETCH;
          pmem_rd_next   = 1'b1;
          pmem_addr_next = pc;
        end
      end

      S_FETCH: begin
        if (accept) begin
          // The word is captured once, here; it then stays on instr until
          // the next accepted fetch.
          state_next = S_ISSUE;
          instr_next = bus.pmem_data;
          id_ce_next = 1'b1;
        end else begin
          // Unbounded wait: keep the request and address steady.
          pmem_rd_next   = 1'b1;
          pmem_addr_next = pc;
        end
      end

      S_ISSUE: begin
        pc_next = jmp_en ? jmp_addr : pc_seq;
        if (halt) begin
          state_next  = S_HALTED;
          halted_next = 1'b1;
        end else begin
          // The next fetch goes straight out at the updated pc, which keeps
          // the zero-wait rate at one instruction every two cycles.
          state_next     = S_FETCH;
          pmem_rd_next   = 1'b1;
          pmem_addr_next = pc_next;
        end
      end

      S_HALTED: begin
        if (start && !halt) begin
          state_next     = S_FETCH;
          pmem_rd_next   = 1'b1;
          pmem_addr_next = pc;
        end else begin
          halted_next = 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before this edge, whatever the order.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc            <= '0;
      bus.pmem_addr <= '0;
      bus.pmem_rd   <= 1'b0;
      bus.instr     <= '0;
      bus.id_ce     <= 1'b0;
      halted        <= 1'b0;
    end else begin
      state         <= state_next;
      pc            <= pc_next;
      bus.pmem_addr <= pmem_addr_next;
      bus.pmem_rd   <= pmem_rd_next;
      bus.instr     <= instr_next;
      bus.id_ce     <= id_ce_next;
      halted        <= halted_next;
    end
  end

  // -------------------------------------------------------------------------
  // Protocol properties.
  // -------------------------------------------------------------------------

  // A new fetch never overlaps the issue of the previous word.
  a_no_fetch_during_issue : assert property (
    @(posedge clk) disable iff (!rst_n) bus.id_ce |-> !bus.pmem_rd
  );

  // Each word is issued exactly once.
  a_single_issue_pulse : assert property (
    @(posedge clk) disable iff (!rst_n) bus.id_ce |=> !bus.id_ce
  );

  // A halted sequencer is completely quiet.
  a_halted_quiet : assert property (
    @(posedge clk) disable iff (!rst_n) halted |-> (!bus.pmem_rd && !bus.id_ce)
  );

  // While memory is stalling, the request and address are held.
  a_wait_holds_request : assert property (
    @(posedge clk) disable iff (!rst_n)
      (bus.pmem_rd && !bus.pmem_valid) |=> (bus.pmem_rd && $stable(bus.pmem_addr))
  );

endmodule : instr_fetch
